pt_write_buffer: RTL and testbench
==================================

// Module: pt_write_buffer
// PURPOSE
//  Write buffer between projective_transform and memory_interface. Accepts
//  transformed pixels (pt_pixel_write, pt_x, pt_y, pt_wr) and drops off-screen
//  coordinates. Converts (x,y) to a linear frame-buffer address. Queues
//  accepted writes in a FIFO and drains them to memory on a wr/grant handshake.
//  Drives ptflag back upstream so the transform stalls before the FIFO overflows.
// PARAMETERS
//  DEPTH   16   FIFO entries (power of two, >=4)
//  AW      4    log2(DEPTH)
//  H_RES   640  valid x range 0..H_RES-1
//  V_RES   480  valid y range 0..V_RES-1
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  pt_pixel_write in   18  pixel data from projective_transform
//  pt_x           in   10  pixel x coordinate
//  pt_y           in   9   pixel y coordinate
//  pt_wr          in   1   write request, one pixel per cycle high
//  ptflag         out  1   upstream may issue pt_wr (registered)
//  mem_addr       out  19  linear address y*640+x of FIFO head
//  mem_data       out  18  pixel data of FIFO head
//  mem_we         out  1   FIFO head valid, write requested
//  mem_grant      in   1   memory accepts head this cycle
//  level          out  AW+1 current FIFO occupancy
//  overflow       out  1   sticky: a write was dropped because FIFO was full
// BEHAVIOUR
//  Only one clock domain. reset: all outputs are 0, the FIFO is emptied, the pipeline
//   valid bit is cleared, and overflow is cleared. This is the same when reset asserts mid-operation.
//  Stage 1 (registered): on pt_wr, the write is in range when pt_x<H_RES and pt_y<V_RES.
//   In range: s1_valid<=1, s1_addr<=(pt_y<<9)+(pt_y<<7)+pt_x (19 bit, no mult),
//   s1_data<=pt_pixel_write. Out of range: silently discarded, no side effect.
//  Stage 2: s1_valid pushes {s1_addr,s1_data} into the FIFO the next cycle.
//   Total latency pt_wr -> mem_we on an empty FIFO = 2 cycles.
//  FIFO: show-ahead. mem_we=!empty; mem_addr/mem_data = head entry
//   (0 when empty). pop = mem_we & mem_grant. mem_grant while empty is ignored.
//  Simultaneous push+pop: level unchanged, both take effect. Push+pop on a
//   full FIFO is legal: pop frees the slot and the push is accepted.
//  Push while full with no pop: entry dropped and overflow<=1 (sticky until reset).
//  Pointers are AW bits and wrap modulo DEPTH. level is 0..DEPTH.
//  ptflag register: ptflag<=((level + s1_valid + in_flight) <= DEPTH-3), where in_flight=pt_wr.
//   The 3-slot margin covers the registered ptflag plus the stage-1 pipe.
//   Upstream may therefore sample ptflag one cycle late without causing overflow.
//  ptflag is 0 during reset and goes 1 on the first cycle after reset deasserts.
//  Ordering: memory writes occur in exactly the order pt_wr was accepted.
//  No flush on frame boundary. Pending writes always drain.
// TESTING
//  1. Single pt_wr x=5,y=2,data=18'h2ABCD, grant tied 1 -> 2 cycles later
//     mem_we=1 for 1 cycle, mem_addr=1285, mem_data=18'h2ABCD.
//  2. pt_wr x=640,y=10 and x=3,y=480 -> no mem_we ever; level stays 0.
//  3. grant=0, stream 20 pt_wr obeying ptflag -> ptflag falls by level 13,
//     overflow stays 0. Then grant=1 -> all accepted writes drain in order.
//  4. grant=0, 20 pt_wr ignoring ptflag -> level=16 and overflow=1. Then grant=1
//     -> exactly 16 writes drain, which are the first 16 issued.
//  5. Full FIFO with grant=1 and pt_wr every cycle -> level holds at 16 and
//     overflow stays 0. Addresses are sequential with no gaps.
//  6. Assert reset for 1 cycle while level=7 -> next cycle mem_we=0, level=0,
//     overflow=0, ptflag=0. The cycle after, ptflag=1.

Source files
------------

// File: rtl/pt_write_buffer.sv
// pt_write_buffer: sits between projective_transform and memory_interface.
// It drops off-screen pixels and turns (x,y) into a linear frame-buffer
// address. Accepted writes are queued in a show-ahead FIFO and drained on a
// we/grant handshake. ptflag tells the upstream transform when it must stall.
module pt_write_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [17:0]   pt_pixel_write,
  input  logic [9:0]    pt_x,
  input  logic [8:0]    pt_y,
  input  logic          pt_wr,
  output logic          ptflag,
  output logic [18:0]   mem_addr,
  output logic [17:0]   mem_data,
  output logic          mem_we,
  input  logic          mem_grant,
  output logic [AW:0]   level,
  output logic          overflow
);

  typedef struct packed {
    logic [18:0] addr;
    logic [17:0] data;
  } entry_t;

  localparam logic [9:0]    X_LIM     = 10'(H_RES);
  localparam logic [8:0]    Y_LIM     = 9'(V_RES);
  localparam logic [AW:0]   LEVEL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] FLAG_LIM  = (AW+2)'(DEPTH - 3);

  // Stage-1 pipeline register
  logic   s1_valid_q, s1_valid_d;
  entry_t s1_entry_q, s1_entry_d;

  // FIFO state
  entry_t          fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic            overflow_q, overflow_d;
  logic            ptflag_q, ptflag_d;

  logic            in_range;
  logic [18:0]     lin_addr;
  logic            empty, full, push, pop, drop;
  logic [AW+1:0]   fill_sum;

  // Stage 1: range check and y*640+x as (y<<9)+(y<<7)+x
  always_comb begin
    in_range   = (pt_x < X_LIM) && (pt_y < Y_LIM);
    lin_addr   = {1'b0, pt_y, 9'd0} + {3'b0, pt_y, 7'd0} + {9'b0, pt_x};
    s1_valid_d = pt_wr && in_range;
    s1_entry_d = s1_entry_q;
    if (s1_valid_d) begin
      s1_entry_d = '{addr: lin_addr, data: pt_pixel_write};
    end
  end

  // FIFO control: push/pop arbitration, occupancy, sticky overflow, ptflag
  always_comb begin
    empty      = (level_q == '0);
    full       = (level_q == LEVEL_MAX);
    pop        = !empty && mem_grant;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push       = s1_valid_q && (!full || pop);
    drop       = s1_valid_q && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    overflow_d = overflow_q || drop;
    // Three-slot margin: one for the registered flag, one for the stage-1
    // entry, one for a request issued while the flag is still seen high.
    fill_sum   = {1'b0, level_q} + (AW+2)'(s1_valid_q) + (AW+2)'(pt_wr);
    ptflag_d   = (fill_sum <= FLAG_LIM);
  end

  // Control and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      ptflag_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_entry_q <= s1_entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      ptflag_q   <= ptflag_d;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; emptiness is tracked by
    // level_q and the head is masked to 0 while empty.
    if (push) begin
      fifo_mem[wr_ptr_q] <= s1_entry_q;
    end
  end

  // Show-ahead head and status outputs
  always_comb begin
    mem_we   = !empty;
    mem_addr = empty ? '0 : fifo_mem[rd_ptr_q].addr;
    mem_data = empty ? '0 : fifo_mem[rd_ptr_q].data;
    level    = level_q;
    overflow = overflow_q;
    ptflag   = ptflag_q;
  end

endmodule

// File: tb/tb_pt_write_buffer.sv
// Directed bench for pt_write_buffer: latency, range drop, ptflag stall,
// overflow, full-FIFO streaming and mid-operation reset.
module tb_pt_write_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic [18:0] mem_addr;
  logic [17:0] mem_data;
  logic        mem_we;
  logic        mem_grant;
  logic [4:0]  level;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [36:0] got_q[$];
  logic [36:0] exp_q[$];

  pt_write_buffer dut (
    .clk(clk), .reset(reset), .pt_pixel_write(pt_pixel_write),
    .pt_x(pt_x), .pt_y(pt_y), .pt_wr(pt_wr), .ptflag(ptflag),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .mem_grant(mem_grant), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Record every completed memory write (inputs change at posedge+1).
  always @(negedge clk) begin
    if (mem_we && mem_grant) got_q.push_back({mem_addr, mem_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] mk(input int x, input int y, input logic [17:0] d);
    logic [18:0] a;
    a = 19'(y * 640 + x);
    return {a, d};
  endfunction

  task automatic drive(input int x, input int y, input logic [17:0] d, input bit expect_it);
    pt_wr          = 1'b1;
    pt_x           = 10'(x);
    pt_y           = 9'(y);
    pt_pixel_write = d;
    if (expect_it) exp_q.push_back(mk(x, y, d));
  endtask

  task automatic cmp_queues(input string tag, input int n_exp);
    check({tag, "_count"}, 64'(got_q.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
      check($sformatf("%s_entry%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; pt_wr = 1'b0; mem_grant = 1'b0;
    step();
    reset = 1'b0;
    step();
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int  issued;
    bit  seen_fall;
    int  max_level;

    reset = 1'b1; pt_wr = 1'b0; pt_x = '0; pt_y = '0;
    pt_pixel_write = '0; mem_grant = 1'b0;

    // Reset state
    step(); step();
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ptflag", 64'(ptflag), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    reset = 1'b0;
    step();
    check("rst_ptflag_rise", 64'(ptflag), 64'd1);

    // T1: single write, two-cycle latency, one-cycle mem_we with grant tied 1
    mem_grant = 1'b1;
    drive(5, 2, 18'h2ABCD, 1'b0);
    step();
    pt_wr = 1'b0;
    check("t1_we_c1", 64'(mem_we), 64'd0);
    step();
    check("t1_we_c2", 64'(mem_we), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'd1285);
    check("t1_data", 64'(mem_data), 64'h2ABCD);
    step();
    check("t1_we_c3", 64'(mem_we), 64'd0);
    check("t1_level", 64'(level), 64'd0);

    // T2: off-screen writes are silently discarded
    drive(640, 10, 18'h1111, 1'b0);
    step();
    drive(3, 480, 18'h2222, 1'b0);
    step();
    pt_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_we_%0d", i), 64'(mem_we), 64'd0);
      check($sformatf("t2_level_%0d", i), 64'(level), 64'd0);
      step();
    end
    check("t2_overflow", 64'(overflow), 64'd0);

    // T3: stream 20 writes obeying ptflag with grant low, then drain
    do_reset();
    issued = 0; seen_fall = 1'b0; max_level = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (ptflag && issued < 20) begin
        drive(issued, 1, 18'h100 + 18'(issued), 1'b1);
        issued++;
      end else begin
        pt_wr = 1'b0;
      end
      step();
      if (!seen_fall && !ptflag) begin
        check("t3_level_at_fall", 64'(level), 64'd13);
        seen_fall = 1'b1;
      end
      if (int'(level) > max_level) max_level = int'(level);
    end
    pt_wr = 1'b0;
    check("t3_seen_fall", 64'(seen_fall), 64'd1);
    check("t3_level_stalled", 64'(level), 64'd14);
    check("t3_ovf_stalled", 64'(overflow), 64'd0);
    mem_grant = 1'b1;
    for (int cyc = 0; cyc < 100 && got_q.size() < 20; cyc++) begin
      if (ptflag && issued < 20) begin
        drive(issued, 1, 18'h100 + 18'(issued), 1'b1);
        issued++;
      end else begin
        pt_wr = 1'b0;
      end
      step();
      if (int'(level) > max_level) max_level = int'(level);
    end
    pt_wr = 1'b0;
    step(); step();
    check("t3_max_level", 64'(max_level), 64'd14);
    check("t3_overflow", 64'(overflow), 64'd0);
    check("t3_level_end", 64'(level), 64'd0);
    cmp_queues("t3", 20);

    // T5: full FIFO with grant high and a write every cycle holds at 16
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      drive(c, 0, 18'h5000 + 18'(c), 1'b1);
      mem_grant = (c >= 17);
      step();
      if (c >= 16) check($sformatf("t5_level_%0d", c), 64'(level), 64'd16);
    end
    pt_wr = 1'b0;
    for (int cyc = 0; cyc < 40 && got_q.size() < 41; cyc++) step();
    step(); step();
    check("t5_overflow", 64'(overflow), 64'd0);
    check("t5_level_end", 64'(level), 64'd0);
    cmp_queues("t5", 41);

    // T4: 20 writes ignoring ptflag overflow a 16-entry FIFO
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(i, 3, 18'h3000 + 18'(i), i < 16);
      step();
    end
    pt_wr = 1'b0;
    step(); step(); step();
    check("t4_level_full", 64'(level), 64'd16);
    check("t4_overflow", 64'(overflow), 64'd1);
    check("t4_ptflag", 64'(ptflag), 64'd0);
    mem_grant = 1'b1;
    for (int cyc = 0; cyc < 40 && level != 0; cyc++) step();
    step(); step(); step();
    check("t4_level_end", 64'(level), 64'd0);
    check("t4_ovf_sticky", 64'(overflow), 64'd1);
    cmp_queues("t4", 16);

    // T6: reset for one cycle at level 7 (overflow still set from T4)
    mem_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(i, 7, 18'h600 + 18'(i), 1'b0);
      step();
    end
    pt_wr = 1'b0;
    step(); step();
    check("t6_level_pre", 64'(level), 64'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_we", 64'(mem_we), 64'd0);
    check("t6_level", 64'(level), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_ptflag", 64'(ptflag), 64'd0);
    step();
    check("t6_ptflag_rise", 64'(ptflag), 64'd1);
    check("t6_we_after", 64'(mem_we), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
